exe_div_unit: RTL and testbench
===============================

Name: exe_div_unit

Overview:
- Iterative radix-2 integer divider in the execute stage.
- Consumes the ALU operand pair s1/s2 produced by the ALU input operand mux; executes RV32M DIV/DIVU/REM/REMU.
- Holds the pipeline via busy until a registered result is presented with a one-cycle done pulse.
- Sits beside the ALU; its result joins the EX result mux ahead of the EX/MEM register.

Parameters:
DATA_WIDTH, 32, operand/result width; equals `DATA_WIDTH.
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a divide; sampled only in IDLE.
flush  input  1  pipeline flush; abandons any operation in flight.
div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
s1  input  DATA_WIDTH  dividend (low DATA_WIDTH bits of SIMD operand s1).
s2  input  DATA_WIDTH  divisor (low DATA_WIDTH bits of SIMD operand s2).
busy  output  1  unit occupied; EX-stage stall request.
done  output  1  one-cycle pulse: result valid.
result  output  DATA_WIDTH  quotient or remainder, registered.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, busy=0, done=0, result=0; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE. busy=1 in CALC, FIX and DONE; busy=0 in IDLE. done=1 only in DONE.
- Cycle numbering: the cycle in which start=1 is sampled in IDLE is cycle 0.
- Accept: in IDLE with start=1 and flush=0, latch div_op, sign flags, |s1| and |s2|. Absolute values apply only for DIV/REM; DIVU/REMU take operands unsigned.
- Fast path, decided in cycle 0 and going IDLE->DONE, with done in cycle 1:
  - Divide by zero (s2==0): quotient=all ones; remainder=s1.
  - Signed overflow (DIV/REM, s1=0x80000000, s2=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- Normal path:
  - IDLE->CALC.
  - CALC runs exactly DATA_WIDTH cycles (cycles 1..32): shift remainder left by 1, bring in the next dividend MSB, trial-subtract divisor, set quotient bit if the result is non-negative (restoring).
  - CALC->FIX when counter reaches DATA_WIDTH-1.
  - FIX (cycle 33): signed ops negate the quotient if the operand signs differ; the remainder takes the dividend's sign. Select quotient or remainder per div_op and write the result register.
  - DONE in cycle 34 (latency DATA_WIDTH+2).
- DONE->IDLE unconditionally after one cycle. result holds its value until the next FIX or fast-path write; it is unchanged by flush.
- start while not IDLE is ignored; no queuing. In DONE, start is not accepted; the EX stage re-presents the request after done.
- flush=1 in any state: next state IDLE, counter cleared, no done pulse.
- flush and start both high in IDLE: flush wins; the request is dropped.
- Counter saturates at 0 outside CALC; it never wraps into a spurious iteration.
- s1/s2 may change after cycle 0 without affecting the operation.
- rst asserted mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- DIVU: s1=100, s2=7, start pulse -> busy cycles 1..34, done=1 in cycle 34 only, result=14; REMU repeat -> result=2.
- Signed: DIV s1=-20 (0xFFFFFFEC), s2=3 -> result=0xFFFFFFFA (-6); REM -> result=0xFFFFFFFE (-2); REM s1=20, s2=-3 -> result=2.
- Divide by zero: DIV s1=5, s2=0 -> done in cycle 1, result=0xFFFFFFFF; REMU s1=5, s2=0 -> result=5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> done in cycle 1, result=0x80000000; REM same operands -> result=0.
- Flush in cycle 10 of a DIVU -> busy=0 from cycle 11, no done pulse, previous result unchanged. A new start the next cycle completes correctly. Flush+start together in IDLE -> busy stays 0.
- start pulses during CALC ignored (the first op's result is correct, and exactly one done occurs). rst asserted in cycle 20 -> outputs 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/exe_div_unit.sv
// rtl/exe_div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module exe_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] s1,
  input  logic [DATA_WIDTH-1:0] s2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]  cnt;
  logic [1:0]            op_q;
  logic                  neg_q;
  logic                  neg_r;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dvsr;

  logic                  is_signed;
  logic                  s1_neg;
  logic                  s2_neg;
  logic [DATA_WIDTH-1:0] s1_abs;
  logic [DATA_WIDTH-1:0] s2_abs;
  logic                  div_zero;
  logic                  overflow;
  logic                  fast;
  logic                  accept;
  logic [DATA_WIDTH-1:0] fast_result;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] q_fix;
  logic [DATA_WIDTH-1:0] r_fix;

  // operand decode and fast-path detection for the request presented in IDLE
  always_comb begin
    is_signed   = ~div_op[0];
    s1_neg      = is_signed & s1[DATA_WIDTH-1];
    s2_neg      = is_signed & s2[DATA_WIDTH-1];
    s1_abs      = s1_neg ? ('0 - s1) : s1;
    s2_abs      = s2_neg ? ('0 - s2) : s2;
    div_zero    = (s2 == '0);
    overflow    = is_signed & (s1 == MIN_INT) & (s2 == '1);
    fast        = div_zero | overflow;
    accept      = (state == IDLE) & start & ~flush;
    fast_result = '0;
    if (div_zero) begin
      fast_result = div_op[1] ? s1 : '1;
    end else if (overflow) begin
      fast_result = div_op[1] ? '0 : MIN_INT;
    end
  end

  // one restoring step: shift in next dividend bit and trial-subtract the divisor
  always_comb begin
    shifted = {rem, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    q_fix   = neg_q ? ('0 - quo) : quo;
    r_fix   = neg_r ? ('0 - rem) : rem;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // iteration counter, held at zero whenever the next cycle is not a CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == CALC) && (state_nxt == CALC)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else begin
      cnt <= '0;
    end
  end

  // operand latch and quotient/remainder shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
    end else if (accept) begin
      op_q  <= div_op;
      neg_q <= s1_neg ^ s2_neg;
      neg_r <= s1_neg;
      quo   <= s1_abs;
      rem   <= '0;
      dvsr  <= s2_abs;
    end else if ((state == CALC) && !flush) begin
      if (!diff[DATA_WIDTH]) begin
        rem <= diff[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // result register: written only by the fast path or by FIX, never by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (accept && fast) begin
      result <= fast_result;
    end else if ((state == FIX) && !flush) begin
      result <= op_q[1] ? r_fix : q_fix;
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// tb/tb_exe_div_unit.sv - self-checking bench for exe_div_unit against an arithmetic reference
module tb_exe_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  div_op;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_assert;
  int n_fail;
  logic [31:0] last_exp;

  exe_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .div_op(div_op),
    .s1(s1), .s2(s2), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cycle 0 is the cycle start is presented; checks busy every cycle, done timing and value
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] exp;
    int lat;
    int cyc;
    bit seen;
    exp = ref_div(op, a, b);
    lat = ref_lat(op, a, b);
    div_op = op; s1 = a; s2 = b; start = 1'b1; flush = 1'b0;
    check("busy_cycle0", 32'(busy), 32'd0);
    step();
    s1 = $urandom; s2 = $urandom; div_op = 2'($urandom);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      check("busy_during_op", 32'(busy), 32'd1);
      if (done) begin
        check("done_cycle", 32'(cyc), 32'(lat));
        check("result", result, exp);
        seen = 1'b1;
      end else begin
        step();
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    start = noise ? 1'b1 : 1'b0;
    step();
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_after_done", 32'(done), 32'd0);
    check("result_held", result, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_assert = 0;
    n_fail   = 0;
    last_exp = 32'd0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = 2'b00; s1 = '0; s2 = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    step();

    do_op(2'b01, 32'd100, 32'd7, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0);
    do_op(2'b00, 32'hFFFF_FFEC, 32'd3, 1'b0);
    check("div_neg20_3", last_exp, 32'hFFFF_FFFA);
    do_op(2'b10, 32'hFFFF_FFEC, 32'd3, 1'b0);
    do_op(2'b10, 32'd20, 32'hFFFF_FFFD, 1'b0);
    do_op(2'b00, 32'd5, 32'd0, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // start pulses during CALC and in DONE are ignored
    do_op(2'b01, 32'd123456, 32'd789, 1'b1);
    do_op(2'b00, 32'hDEAD_BEEF, 32'd17, 1'b1);

    // flush in cycle 10 of a DIVU, then a fresh request in cycle 11
    div_op = 2'b01; s1 = 32'd1000; s2 = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      check("busy_pre_flush", 32'(busy), 32'd1);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, last_exp);
    do_op(2'b01, 32'd1000, 32'd3, 1'b0);

    // flush and start together in IDLE drop the request
    div_op = 2'b01; s1 = 32'd50; s2 = 32'd5; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    step();
    check("flush_start_busy2", 32'(busy), 32'd0);
    check("flush_start_result", result, last_exp);

    // asynchronous reset in cycle 20
    div_op = 2'b00; s1 = 32'd99999; s2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    check("busy_pre_rst", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    last_exp = 32'd0;

    // randomized operations with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
